// File: rtl/sync_gen_pkg.sv
// Shared types and helpers for the camera-locked timing generator.
package sync_gen_pkg;

  typedef enum logic [1:0] {
    UNINIT   = 2'd0,
    WAITING  = 2'd1,
    DELAYING = 2'd2,
    LOCKED   = 2'd3
  } lock_state_e;

  function automatic int calc_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_timing.sv
// H/V position counters, sync/active decode and the two-stage output pipeline.
// Everything is held at its reset value while run is low.
module sync_timing
  import sync_gen_pkg::*;
#(
  parameter int H_ACT    = 1280,
  parameter int V_ACT    = 720,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1,
  localparam int H_TOTAL = calc_total(H_ACT, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = calc_total(V_ACT, V_FP, V_SYNC, V_BP),
  localparam int X_BITS  = $clog2(H_TOTAL),
  localparam int Y_BITS  = $clog2(V_TOTAL)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  output logic              vsync,
  output logic              hsync,
  output logic              data_en,
  output logic              read_en,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic [7:0]        frame_cnt,
  output logic              frame_wrap
);

  localparam logic [X_BITS-1:0] H_LAST = X_BITS'(H_TOTAL - 1);
  localparam logic [Y_BITS-1:0] V_LAST = Y_BITS'(V_TOTAL - 1);
  localparam logic [X_BITS-1:0] H_ACT_W = X_BITS'(H_ACT);
  localparam logic [Y_BITS-1:0] V_ACT_W = Y_BITS'(V_ACT);
  localparam logic [X_BITS-1:0] HS_BEG = X_BITS'(H_ACT + H_FP);
  localparam logic [X_BITS-1:0] HS_END = X_BITS'(H_ACT + H_FP + H_SYNC);
  localparam logic [Y_BITS-1:0] VS_BEG = Y_BITS'(V_ACT + V_FP);
  localparam logic [Y_BITS-1:0] VS_END = Y_BITS'(V_ACT + V_FP + V_SYNC);

  logic [X_BITS-1:0] h;
  logic [Y_BITS-1:0] v;
  logic              act_c, hs_c, vs_c;
  logic              hs1, vs1;
  logic [X_BITS-1:0] x1;
  logic [Y_BITS-1:0] y1;

  assign frame_wrap = run && (h == H_LAST) && (v == V_LAST);
  assign act_c = run && (h < H_ACT_W) && (v < V_ACT_W);
  assign hs_c  = run && (h >= HS_BEG) && (h < HS_END);
  assign vs_c  = run && (v >= VS_BEG) && (v < VS_END);

  // Line/frame position, parked at the origin until timing runs
  always_ff @(posedge clk) begin
    if (!rstn || !run) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // read_en is stage 1 of the pipeline; the display outputs are stage 2
  always_ff @(posedge clk) begin
    if (!rstn || !run) begin
      read_en <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      x1      <= '0;
      y1      <= '0;
      data_en <= 1'b0;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
      x       <= '0;
      y       <= '0;
    end else begin
      read_en <= act_c;
      hs1     <= hs_c;
      vs1     <= vs_c;
      x1      <= act_c ? h : '0;
      y1      <= act_c ? v : '0;
      data_en <= read_en;
      hsync   <= hs1 ^ ~SYNC_POL;
      vsync   <= vs1 ^ ~SYNC_POL;
      x       <= x1;
      y       <= y1;
    end
  end

  // Frames produced since the current lock
  always_ff @(posedge clk) begin
    if (!rstn || !run) begin
      frame_cnt <= 8'd0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/sync_gen_lock.sv
// Camera-locked video timing generator: blank detector FSM plus free-running timing.
// Optional relock monitor enabled by defining SYNC_GEN_RELOCK_EN.
module sync_gen_lock
  import sync_gen_pkg::*;
#(
  parameter int H_ACT    = 1280,
  parameter int V_ACT    = 720,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int THRESH   = 1000,
  parameter int DELAY    = 0,
  parameter bit SYNC_POL = 1'b1,
  parameter int LOST_FRM = 2,
  localparam int H_TOTAL = calc_total(H_ACT, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = calc_total(V_ACT, V_FP, V_SYNC, V_BP),
  localparam int X_BITS  = $clog2(H_TOTAL),
  localparam int Y_BITS  = $clog2(V_TOTAL)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cam_href,
  output logic              vsync,
  output logic              hsync,
  output logic              data_en,
  output logic              read_en,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              locked,
  output logic              lost,
  output logic [7:0]        frame_cnt
);

  localparam int CNT_W = $clog2(((THRESH > DELAY) ? THRESH : DELAY) + 1);
  localparam logic [CNT_W-1:0] THR_LAST = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = (DELAY > 0) ? CNT_W'(DELAY - 1) : '0;

  lock_state_e      state, next_state;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             href_d, fall, run, frame_wrap, lost_nx;

  assign fall = href_d && !cam_href;
  assign run  = (state == LOCKED);

`ifdef SYNC_GEN_RELOCK_EN
  localparam int MISS_W = $clog2(LOST_FRM + 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOST_FRM - 1);
  logic              det_on, det_on_nx, blank_seen, seen_nx, det_hit;
  logic [MISS_W-1:0] miss, miss_nx;
`else
  logic unused_relock;
  assign unused_relock = frame_wrap & (LOST_FRM > 0);
`endif

  // Next-state logic; while LOCKED the same counter can run the blank detector
  always_comb begin
    next_state = state;
    cnt_nx     = cnt;
    lost_nx    = 1'b0;
`ifdef SYNC_GEN_RELOCK_EN
    det_on_nx  = 1'b0;
    seen_nx    = 1'b0;
    miss_nx    = '0;
    det_hit    = 1'b0;
`endif
    case (state)
      UNINIT: begin
        cnt_nx = '0;
        if (fall) begin
          next_state = WAITING;
        end else begin
          next_state = UNINIT;
        end
      end
      WAITING: begin
        if (cam_href) begin
          next_state = UNINIT;
          cnt_nx     = '0;
        end else if (cnt == THR_LAST) begin
          next_state = (DELAY == 0) ? LOCKED : DELAYING;
          cnt_nx     = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DELAYING: begin
        if (cnt == DLY_LAST) begin
          next_state = LOCKED;
          cnt_nx     = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      LOCKED: begin
`ifdef SYNC_GEN_RELOCK_EN
        det_on_nx = det_on;
        seen_nx   = blank_seen;
        miss_nx   = miss;
        if (!det_on) begin
          det_on_nx = fall;
          cnt_nx    = '0;
        end else if (cam_href) begin
          det_on_nx = 1'b0;
          cnt_nx    = '0;
        end else if (cnt == THR_LAST) begin
          det_on_nx = 1'b0;
          cnt_nx    = '0;
          det_hit   = 1'b1;
          seen_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
        // A blank found on the wrap cycle itself still counts for the ending frame
        if (frame_wrap) begin
          seen_nx = 1'b0;
          if (blank_seen || det_hit) begin
            miss_nx = '0;
          end else if (miss == MISS_LAST) begin
            lost_nx    = 1'b1;
            next_state = UNINIT;
            miss_nx    = '0;
            det_on_nx  = 1'b0;
            cnt_nx     = '0;
          end else begin
            miss_nx = miss + 1'b1;
          end
        end else begin
          lost_nx = 1'b0;
        end
`else
        cnt_nx = '0;
`endif
      end
      default: begin
        next_state = UNINIT;
        cnt_nx     = '0;
      end
    endcase
  end

  // Lock FSM state, detector counter and status flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= UNINIT;
      cnt    <= '0;
      href_d <= 1'b1;
      locked <= 1'b0;
      lost   <= 1'b0;
`ifdef SYNC_GEN_RELOCK_EN
      det_on     <= 1'b0;
      blank_seen <= 1'b0;
      miss       <= '0;
`endif
    end else begin
      state  <= next_state;
      cnt    <= cnt_nx;
      href_d <= cam_href;
      locked <= (state == LOCKED) && (next_state == LOCKED);
      lost   <= lost_nx;
`ifdef SYNC_GEN_RELOCK_EN
      det_on     <= det_on_nx;
      blank_seen <= seen_nx;
      miss       <= miss_nx;
`endif
    end
  end

  sync_timing #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk        (clk),
    .rstn       (rstn),
    .run        (run),
    .vsync      (vsync),
    .hsync      (hsync),
    .data_en    (data_en),
    .read_en    (read_en),
    .x          (x),
    .y          (y),
    .frame_cnt  (frame_cnt),
    .frame_wrap (frame_wrap)
  );

endmodule
